// File: rtl/dcache_line_ctrl_if.sv
// Bus bundle between the data-cache controller, the CPU MEM stage, the 16:1 line mux and memory.
// The controller takes the slave modport; the surrounding environment takes master.
interface dcache_line_ctrl_if #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned OFFSET_W = 4
);
    localparam int unsigned BLOCK_W = 8 << OFFSET_W;

    logic [ADDR_W-1:0]          ADDRESS;
    logic                       READ;
    logic                       WRITE;
    logic [31:0]                WRITE_DATA;
    logic [3:0]                 BYTE_MASK;
    logic [31:0]                READ_DATA;
    logic                       BUSYWAIT;
    logic [3:0]                 LINE_SELECT;
    logic [BLOCK_W-1:0]         BLOCK_IN;
    logic                       LINE_WRITE_EN;
    logic [BLOCK_W-1:0]         LINE_WRITE_DATA;
    logic                       MEM_READ;
    logic                       MEM_WRITE;
    logic [ADDR_W-OFFSET_W-1:0] MEM_ADDRESS;
    logic [BLOCK_W-1:0]         MEM_WRITE_DATA;
    logic [BLOCK_W-1:0]         MEM_READ_DATA;
    logic                       MEM_BUSYWAIT;
    logic [31:0]                HIT_COUNT;
    logic [31:0]                MISS_COUNT;

    modport slave (
        input  ADDRESS, READ, WRITE, WRITE_DATA, BYTE_MASK, BLOCK_IN, MEM_READ_DATA,
               MEM_BUSYWAIT,
        output READ_DATA, BUSYWAIT, LINE_SELECT, LINE_WRITE_EN, LINE_WRITE_DATA, MEM_READ,
               MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA, HIT_COUNT, MISS_COUNT
    );

    modport master (
        output ADDRESS, READ, WRITE, WRITE_DATA, BYTE_MASK, BLOCK_IN, MEM_READ_DATA,
               MEM_BUSYWAIT,
        input  READ_DATA, BUSYWAIT, LINE_SELECT, LINE_WRITE_EN, LINE_WRITE_DATA, MEM_READ,
               MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA, HIT_COUNT, MISS_COUNT
    );
endinterface

// File: rtl/dcache_line_ctrl.sv
// Direct-mapped write-back D-cache controller: tag/valid/dirty arrays, hit logic, word merge, miss FSM.
// Optional hit/miss counters are built only when DCACHE_STATS_EN is defined.
module dcache_line_ctrl #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INDEX_W  = 4,
    parameter int unsigned OFFSET_W = 4
) (
    input logic               CLK,
    input logic               RESET,
    dcache_line_ctrl_if.slave bus
);
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINES   = 1 << INDEX_W;
    localparam int unsigned BLOCK_W = 8 << OFFSET_W;

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate, StUpdate} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [TAG_W-1:0]     r_tag_arr [LINES];
    logic [LINES-1:0]     r_valid;
    logic [LINES-1:0]     r_dirty;
    logic [BLOCK_W-1:0]   r_fill_buf;

    logic [TAG_W-1:0]     w_tag;
    logic [INDEX_W-1:0]   w_index;
    logic [1:0]           w_word;
    logic                 w_req;
    logic                 w_hit;
    logic                 w_hit_evt;
    logic                 w_miss_evt;
    logic                 w_fill_done;
    logic [31:0]          w_word_old;
    logic [31:0]          w_word_new;
    logic [BLOCK_W-1:0]   w_merged_block;
    logic                 w_unused;

    assign w_tag       = bus.ADDRESS[ADDR_W-1:INDEX_W+OFFSET_W];
    assign w_index     = bus.ADDRESS[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign w_word      = bus.ADDRESS[3:2];
    assign w_unused    = ^bus.ADDRESS[1:0];
    assign w_req       = bus.READ | bus.WRITE;
    assign w_hit       = r_valid[w_index] && (r_tag_arr[w_index] == w_tag);
    assign w_hit_evt   = (r_state == StIdle) && w_req && w_hit;
    assign w_miss_evt  = (r_state == StIdle) && w_req && !w_hit;
    assign w_fill_done = (r_state == StAllocate) && !bus.MEM_BUSYWAIT;

    assign w_word_old       = bus.BLOCK_IN[{w_word, 5'd0} +: 32];
    assign bus.READ_DATA    = w_word_old;
    assign bus.LINE_SELECT  = w_index;

    // Store merge: only the enabled byte lanes of the addressed word change
    always_comb begin
        w_word_new = w_word_old;
        for (int i = 0; i < 4; i++) begin
            if (bus.BYTE_MASK[i]) w_word_new[8*i +: 8] = bus.WRITE_DATA[8*i +: 8];
        end
        w_merged_block = bus.BLOCK_IN;
        w_merged_block[{w_word, 5'd0} +: 32] = w_word_new;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_miss_evt) begin
                    w_state_next = (r_valid[w_index] && r_dirty[w_index]) ? StWriteback
                                                                          : StAllocate;
                end
            end
            StWriteback: if (!bus.MEM_BUSYWAIT) w_state_next = StAllocate;
            StAllocate:  if (!bus.MEM_BUSYWAIT) w_state_next = StUpdate;
            StUpdate:    w_state_next = StIdle;
            default:     w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.BUSYWAIT        = 1'b0;
        bus.LINE_WRITE_EN   = 1'b0;
        bus.LINE_WRITE_DATA = w_merged_block;
        bus.MEM_READ        = 1'b0;
        bus.MEM_WRITE       = 1'b0;
        bus.MEM_ADDRESS     = bus.ADDRESS[ADDR_W-1:OFFSET_W];
        bus.MEM_WRITE_DATA  = bus.BLOCK_IN;
        case (r_state)
            StIdle: begin
                if (w_req && !w_hit)        bus.BUSYWAIT      = 1'b1;
                if (w_hit_evt && bus.WRITE) bus.LINE_WRITE_EN = 1'b1;
            end
            StWriteback: begin
                bus.BUSYWAIT    = 1'b1;
                bus.MEM_WRITE   = 1'b1;
                bus.MEM_ADDRESS = {r_tag_arr[w_index], w_index};
            end
            StAllocate: begin
                bus.BUSYWAIT = 1'b1;
                bus.MEM_READ = 1'b1;
            end
            StUpdate: begin
                bus.BUSYWAIT        = 1'b1;
                bus.LINE_WRITE_EN   = 1'b1;
                bus.LINE_WRITE_DATA = r_fill_buf;
            end
            default: bus.BUSYWAIT = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_valid    <= '0;
            r_dirty    <= '0;
            r_fill_buf <= '0;
        end else begin
            if (w_hit_evt && bus.WRITE) r_dirty[w_index] <= 1'b1;
            if (w_fill_done)            r_fill_buf <= bus.MEM_READ_DATA;
            if (r_state == StUpdate) begin
                r_valid[w_index] <= 1'b1;
                r_dirty[w_index] <= 1'b0;
            end
        end
    end

    // Tags are qualified by valid, so they need no reset
    always_ff @(posedge CLK) begin
        if (r_state == StUpdate) r_tag_arr[w_index] <= w_tag;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit_evt && (r_hit_count != 32'hFFFF_FFFF))   r_hit_count  <= r_hit_count + 32'd1;
            if (w_miss_evt && (r_miss_count != 32'hFFFF_FFFF)) r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign bus.HIT_COUNT  = r_hit_count;
    assign bus.MISS_COUNT = r_miss_count;
`else
    assign bus.HIT_COUNT  = '0;
    assign bus.MISS_COUNT = '0;
`endif
endmodule
